// File: rtl/intctrl_vec.sv
// rtl/intctrl_vec.sv - vectored priority interrupt controller with byte-lane register bus
module intctrl_vec #(
    parameter int         NUM_IRQ     = 8,
    parameter logic [7:0] VECTOR_BASE = 8'h40
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [15:0]        data_write,
    output logic [15:0]        data_read,
    input  logic [7:0]         addr,
    input  logic               uds,
    input  logic               lds,
    input  logic               rw,
    input  logic               as,
    input  logic               iack,
    input  logic [2:0]         iack_level,
    output logic               ack,
    output logic [2:0]         ipl_n,
    input  logic [NUM_IRQ-1:0] irq
);
    localparam logic [7:0] SPURIOUS_VECTOR = 8'h18;

    logic [NUM_IRQ-1:0] sync1, sync2, sync_prev;
    logic               gie;
    logic [NUM_IRQ-1:0] enable, pending, mode;
    logic [2:0]         level [NUM_IRQ];
    logic               armed;

    logic [6:0]         word;
    logic               access, do_write, do_iack;
    logic [15:0]        lane_mask;
    logic [NUM_IRQ-1:0] lane_bits, wr_bits;

    assign word      = addr[7:1];
    assign access    = as & armed;
    assign do_write  = access & ~iack & ~rw;
    assign do_iack   = access & iack & rw;
    assign lane_mask = {{8{uds}}, {8{lds}}};
    assign lane_bits = lane_mask[NUM_IRQ-1:0];
    assign wr_bits   = data_write[NUM_IRQ-1:0] & lane_bits;

    logic unused_bits;
    assign unused_bits = ^{data_write, addr[0], lane_mask};

    // Priority resolution: highest level wins, descending scan with >= lets lower index win ties
    logic [NUM_IRQ-1:0] level_nz, cand;
    logic [2:0]         win_level, cur_level;
    logic [3:0]         win_idx, act_idx;
    logic [7:0]         vector;
    logic               iack_hit;

    always_comb begin
        level_nz = '0;
        for (int i = 0; i < NUM_IRQ; i++) level_nz[i] = |level[i];
    end

    assign cand = pending & enable & level_nz;

    always_comb begin
        win_level = 3'd0;
        win_idx   = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (cand[i] && level[i] >= win_level) begin
                win_level = level[i];
                win_idx   = 4'(i);
            end
        end
    end

    assign cur_level = gie ? win_level : 3'd0;
    assign act_idx   = (cur_level != 3'd0) ? win_idx : 4'd0;
    assign vector    = VECTOR_BASE + {4'd0, win_idx};
    assign iack_hit  = (cur_level != 3'd0) && (iack_level == cur_level);

    // Edge-mode sources hold until cleared; a fresh edge beats a same-cycle clear
    logic [NUM_IRQ-1:0] edge_det, clr, pending_next;
    assign edge_det = sync2 & ~sync_prev;

    always_comb begin
        clr = '0;
        if (do_write && word == 7'd2) clr = wr_bits;
        if (do_iack && iack_hit) begin
            for (int i = 0; i < NUM_IRQ; i++)
                if (4'(i) == win_idx) clr[i] = 1'b1;
        end
    end

    assign pending_next = (mode & ((pending & ~clr) | edge_det)) | (~mode & sync2);

    logic [15:0] rd_data;
    always_comb begin
        rd_data = '0;
        if (iack) begin
            rd_data[7:0] = iack_hit ? vector : SPURIOUS_VECTOR;
        end else begin
            case (word)
                7'd0: rd_data[0] = gie;
                7'd1: rd_data[NUM_IRQ-1:0] = enable;
                7'd2: rd_data[NUM_IRQ-1:0] = pending;
                7'd3: rd_data[NUM_IRQ-1:0] = mode;
                7'd4, 7'd5, 7'd6, 7'd7: begin
                    for (int i = 0; i < NUM_IRQ; i++)
                        if (word == 7'(4 + i / 4)) rd_data[4*(i%4) +: 3] = level[i];
                end
                7'd8: rd_data = {4'h0, act_idx, 5'h00, cur_level};
                default: rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1     <= '0;
            sync2     <= '0;
            sync_prev <= '0;
            gie       <= 1'b0;
            enable    <= '0;
            pending   <= '0;
            mode      <= '0;
            for (int i = 0; i < NUM_IRQ; i++) level[i] <= 3'd0;
            armed     <= 1'b0;
            ack       <= 1'b0;
            data_read <= '0;
            ipl_n     <= 3'b111;
        end else begin
            sync1     <= irq;
            sync2     <= sync1;
            sync_prev <= sync2;
            pending   <= pending_next;
            ack       <= access;
            data_read <= (access && rw) ? rd_data : 16'h0000;
            ipl_n     <= (cur_level != 3'd0) ? ~cur_level : 3'b111;

            // One ack per strobe: re-arm only after as has been seen low
            if (!as)
                armed <= 1'b1;
            else if (access)
                armed <= 1'b0;

            if (do_write) begin
                if (word == 7'd0 && lds) gie <= data_write[0];
                if (word == 7'd1) enable <= (enable & ~lane_bits) | wr_bits;
                if (word == 7'd3) mode <= (mode & ~lane_bits) | wr_bits;
                for (int i = 0; i < NUM_IRQ; i++) begin
                    if (word == 7'(4 + i / 4) && (((i % 4) >= 2) ? uds : lds))
                        level[i] <= data_write[4*(i%4) +: 3];
                end
            end
        end
    end
endmodule
